shift_engine_seq: RTL and testbench

//   Multi-cycle shift/rotate engine, one bit position per clock.

---
 rtl/shift_pkg.sv | 15 +
 rtl/shift1_unit.sv | 23 ++
 rtl/shift_engine_seq.sv | 82 ++++++++
 tb/tb_shift_engine_seq.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared op codes and FSM state type for the sequential shift engine.
package shift_pkg;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_ROL = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/shift1_unit.sv
// Combinational single-position shift/rotate, selected by op.
module shift1_unit
  import shift_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = a;
    case (op)
      OP_SLL:  y = {a[WIDTH-2:0], 1'b0};
      OP_SRL:  y = {1'b0, a[WIDTH-1:1]};
      OP_ROL:  y = {a[WIDTH-2:0], a[WIDTH-1]};
      OP_ROR:  y = {a[0], a[WIDTH-1:1]};
      default: y = a;
    endcase
  end

endmodule

// File: rtl/shift_engine_seq.sv
// Multi-cycle shift/rotate engine: one bit position per clock behind
// valid/ready request and result ports.
module shift_engine_seq
  import shift_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] i,
  input  logic [SHW-1:0]   shift,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] o,
  output logic             busy
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] step;
  logic [SHW-1:0]   count_q;
  logic [1:0]       op_q;
  logic             accept;

  shift1_unit #(.WIDTH(WIDTH)) u_shift1 (
    .a  (acc_q),
    .op (op_q),
    .y  (step)
  );

  assign accept = in_valid && in_ready;
  assign o      = acc_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = (shift == '0) ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        busy = 1'b1;
        if (count_q == SHW'(1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // count parks at 1 on the final RUN edge rather than reaching zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q   <= '0;
      count_q <= '0;
      op_q    <= OP_SLL;
    end else if (accept) begin
      acc_q   <= i;
      count_q <= shift;
      op_q    <= op;
    end else if (state_q == ST_RUN) begin
      acc_q <= step;
      if (count_q != SHW'(1)) count_q <= count_q - SHW'(1);
    end
  end

endmodule

// File: tb/tb_shift_engine_seq.sv
// Self-checking bench for shift_engine_seq: directed cases plus randomized
// back-to-back traffic against an arithmetic shift/rotate reference.
`timescale 1ns/1ps
module tb_shift_engine_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] i;
  logic [3:0]  shift;
  logic [1:0]  op;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] o;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  shift_engine_seq #(.WIDTH(16), .SHW(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .i         (i),
    .shift     (shift),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .o         (o),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Barrel reference: rotates taken from a doubled operand.
  function automatic logic [15:0] ref_shift(input logic [15:0] x, input int k, input logic [1:0] opc);
    logic [31:0] d;
    logic [31:0] r;
    d = {x, x};
    case (opc)
      2'b00:   r = {16'h0, x} << k;
      2'b01:   r = {16'h0, x} >> k;
      2'b10:   r = d >> (16 - k);
      default: r = d >> k;
    endcase
    return r[15:0];
  endfunction

  task automatic req(input string tag, input logic [1:0] opc, input logic [3:0] sh,
                     input logic [15:0] din, input logic [15:0] exp);
    int lat;
    @(negedge clk);
    check({tag, "_ready"}, 32'(in_ready), 32'd1);
    i = din; shift = sh; op = opc; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, 32'(lat - 1), 32'(sh));
    check({tag, "_o"}, 32'(o), 32'(exp));
    check({tag, "_model"}, 32'(o), 32'(ref_shift(din, int'(sh), opc)));
    check({tag, "_busy"}, 32'(busy), 32'd1);
    @(negedge clk);
    check({tag, "_release"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, w, prev_cyc, prev_k, acc_cyc;
    logic [15:0] exp;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    i = '0; shift = '0; op = '0;
    #2;
    check("rst_o", 32'(o), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    req("srl1", 2'b01, 4'd1, 16'h8005, 16'h4002);
    req("ror1", 2'b11, 4'd1, 16'h8005, 16'hC002);
    req("sll1", 2'b00, 4'd1, 16'h8005, 16'h000A);
    req("rol1", 2'b10, 4'd1, 16'h8005, 16'h000B);
    req("rol4", 2'b10, 4'd4, 16'h8005, 16'h0058);
    req("sll15", 2'b00, 4'd15, 16'h8005, 16'h8000);
    req("srl15", 2'b01, 4'd15, 16'h8005, 16'h0001);
    req("ror15", 2'b11, 4'd15, 16'h8005, 16'h000B);
    for (int k = 0; k < 4; k++) req("zero", 2'(k), 4'd0, 16'h8005, 16'h8005);

    // Result held while consumer stalls.
    @(negedge clk);
    i = 16'h8005; shift = 4'd0; op = 2'b11; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    for (int n = 0; n < 5; n++) begin
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_o", 32'(o), 32'h8005);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    check("hold_release", 32'(out_valid), 32'd0);
    check("hold_idle", 32'(in_ready), 32'd1);

    // Back-to-back random traffic with in_valid held high.
    out_ready = 1'b1; in_valid = 1'b1;
    prev_cyc = 0; prev_k = 0;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      i = 16'($urandom); shift = 4'($urandom_range(0, 15)); op = 2'($urandom_range(0, 3));
      w = 0;
      while (!in_ready && w < 40) begin
        @(negedge clk);
        w++;
      end
      check("b2b_ready", 32'(in_ready), 32'd1);
      exp = ref_shift(i, int'(shift), op);
      acc_cyc = cyc;
      if (n > 0) check("b2b_tput", 32'(acc_cyc - prev_cyc), 32'(prev_k + 2));
      prev_cyc = acc_cyc; prev_k = int'(shift);
      @(negedge clk);
      lat = 1;
      while (!out_valid && lat < 40) begin
        check("b2b_no_accept", 32'(in_ready), 32'd0);
        @(negedge clk);
        lat++;
      end
      check("b2b_lat", 32'(lat - 1), 32'(prev_k));
      check("b2b_o", 32'(o), 32'(exp));
      check("b2b_busy", 32'(busy), 32'd1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (20) @(negedge clk);

    // Reset mid-RUN discards the partial result.
    i = 16'h8005; shift = 4'd9; op = 2'b10; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("rstrun_valid", 32'(out_valid), 32'd0);
    check("rstrun_o", 32'(o), 32'd0);
    check("rstrun_ready", 32'(in_ready), 32'd1);
    check("rstrun_busy", 32'(busy), 32'd0);
    // in_valid already high while reset is still asserted
    @(negedge clk);
    i = 16'h8005; shift = 4'd15; op = 2'b11; in_valid = 1'b1;
    @(negedge clk);
    check("rsthold_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    check("rstrel_accept", 32'(busy), 32'd1);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("rstrel_lat", 32'(lat - 1), 32'd15);
    check("rstrel_o", 32'(o), 32'h000B);
    @(negedge clk);

    // Reset while DONE.
    i = 16'h8005; shift = 4'd2; op = 2'b00; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    w = 0;
    while (!out_valid && w < 40) begin
      @(negedge clk);
      w++;
    end
    check("rstdone_pre_o", 32'(o), 32'h0014);
    reset = 1'b1;
    #1;
    check("rstdone_valid", 32'(out_valid), 32'd0);
    check("rstdone_o", 32'(o), 32'd0);
    check("rstdone_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    req("after_rst", 2'b10, 4'd9, 16'h8005, 16'h0B00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
